tx_arbiter: RTL

Packet-level round-robin arbiter that shares the PCIe core's AXI4-Stream TX port between two TLP sources. Source 0 is the completion path from the TX bridge; source 1 is the requester/message path. A grant is held from a packet's first beat through the beat carrying `last`, so TLPs never interleave. The output is registered, and there is no idle cycle between back-to-back packets.

---
 rtl/tx_pkg.sv | 30 +++
 rtl/tx_out_reg.sv | 45 ++++
 rtl/tx_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// tx_pkg: definitions shared across the PCIe TX path.
//   TX_DATA_W / TX_KEEP_W : AXI4-Stream widths, shared with the TX bridge.
//   arb_state_t           : tx_arbiter grant state encoding.
//   arb_pick()            : round-robin packet-level pick between two sources.
package tx_pkg;

  localparam int unsigned TX_DATA_W = 64;
  localparam int unsigned TX_KEEP_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_t;

  // last_grant = 1 means source 1 was granted most recently, so a tie goes to source 0.
  function automatic arb_state_t arb_pick(input logic v0, input logic v1,
                                          input logic last_grant);
    if (v0 && v1) begin
      return last_grant ? GRANT0 : GRANT1;
    end else if (v0) begin
      return GRANT0;
    end else if (v1) begin
      return GRANT1;
    end else begin
      return IDLE;
    end
  endfunction

endpackage

// File: rtl/tx_out_reg.sv
// tx_out_reg: single-stage AXI4-Stream output register.
//   clk, reset          : clock, synchronous active-high reset
//   load                : a beat is accepted this cycle; capture in_* and raise out_valid
//   in_data/keep/last   : beat to capture
//   out_ready           : downstream ready
//   out_valid/data/keep/last : registered stream towards the PCIe core
//   slot_free           : register can take a beat this cycle (~out_valid | out_ready)
module tx_out_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              slot_free
);

  assign slot_free = ~out_valid | out_ready;

  // Payload only changes on load, so it is stable while stalled and holds after drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: packet-level round-robin arbiter sharing the PCIe TX AXI4-Stream
// port between source 0 (completions) and source 1 (requests/messages).
// A grant is held from first beat through the last beat; re-arbitration happens
// on the accepted last beat, so back-to-back packets have no idle cycle.
//   clk, reset                  : clock, synchronous active-high reset
//   s0_* / s1_*                 : source streams (valid/ready/data/keep/last)
//   AXI_out_*                   : registered stream to the PCIe core
//   pkt_count0 / pkt_count1     : wrapping per-source forwarded-packet counters
//   arb_error                   : sticky stall watchdog flag
// Optional feature: define TX_ARB_WATCHDOG_EN to enable the stall watchdog
// (limit WDOG_CYCLES); otherwise arb_error is tied to 0.
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W      = TX_DATA_W,
  parameter int unsigned KEEP_W      = TX_KEEP_W,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic [KEEP_W-1:0] s0_keep,
  input  logic              s0_last,

  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic [KEEP_W-1:0] s1_keep,
  input  logic              s1_last,

  output logic              AXI_out_valid,
  input  logic              AXI_out_ready,
  output logic [DATA_W-1:0] AXI_out_data,
  output logic [KEEP_W-1:0] AXI_out_keep,
  output logic              AXI_out_last,

  output logic [CNT_W-1:0]  pkt_count0,
  output logic [CNT_W-1:0]  pkt_count1,
  output logic              arb_error
);

  arb_state_t state;
  arb_state_t pick;
  logic       last_grant;
  logic       slot_free;
  logic       acc0;
  logic       acc1;
  logic       load;
  logic [DATA_W-1:0] mux_data;
  logic [KEEP_W-1:0] mux_keep;
  logic              mux_last;

  assign s0_ready = (state == GRANT0) & slot_free;
  assign s1_ready = (state == GRANT1) & slot_free;
  assign acc0     = s0_valid & s0_ready;
  assign acc1     = s1_valid & s1_ready;
  assign load     = acc0 | acc1;
  assign pick     = arb_pick(s0_valid, s1_valid, last_grant);

  always_comb begin
    mux_data = s0_data;
    mux_keep = s0_keep;
    mux_last = s0_last;
    if (acc1) begin
      mux_data = s1_data;
      mux_keep = s1_keep;
      mux_last = s1_last;
    end
  end

  tx_out_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_data   (mux_data),
    .in_keep   (mux_keep),
    .in_last   (mux_last),
    .out_ready (AXI_out_ready),
    .out_valid (AXI_out_valid),
    .out_data  (AXI_out_data),
    .out_keep  (AXI_out_keep),
    .out_last  (AXI_out_last),
    .slot_free (slot_free)
  );

  // Re-arbitrating on the accepted last beat (not after it) gives zero-bubble
  // hand-over; the current source's own valid is part of that pick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      pkt_count0 <= '0;
      pkt_count1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= pick;
          if (pick != IDLE) last_grant <= (pick == GRANT1);
        end
        GRANT0: begin
          if (acc0 && s0_last) begin
            pkt_count0 <= pkt_count0 + CNT_W'(1);
            state      <= pick;
            if (pick != IDLE) last_grant <= (pick == GRANT1);
          end
        end
        GRANT1: begin
          if (acc1 && s1_last) begin
            pkt_count1 <= pkt_count1 + CNT_W'(1);
            state      <= pick;
            if (pick != IDLE) last_grant <= (pick == GRANT1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TX_ARB_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] stall_cnt;
  logic              stalled;
  logic              err_q;

  assign stalled = ((state == GRANT0) & ~s0_valid) |
                   ((state == GRANT1) & ~s1_valid);

  // The grant is never revoked here; the flag only reports the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else if (load || (state == IDLE)) begin
      stall_cnt <= '0;
    end else if (stalled) begin
      if (stall_cnt == WDOG_LIM) begin
        err_q <= 1'b1;
      end else begin
        stall_cnt <= stall_cnt + WDOG_W'(1);
      end
    end
  end

  assign arb_error = err_q;
`else
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = (WDOG_CYCLES == 0);
  assign arb_error       = 1'b0;
`endif

endmodule
